// File: rtl/ifetch_bridge_if.sv
// Fetch-side bundle between the core, the fetch bridge and the instruction memory port.
// The slave modport is the bridge's view; the master modport is the core/memory side.
interface ifetch_bridge_if #(
  parameter int XLEN        = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [XLEN-1:0]        i_pc;
  logic                   i_flush;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic                   o_ifValid;
  logic                   o_imemReq;
  logic [XLEN-1:0]        o_imemAddr;
  logic                   i_imemGnt;
  logic                   i_imemValid;
  logic [31:0]            i_imemData;

  modport slave (
    input  i_pc, i_flush, i_imemGnt, i_imemValid, i_imemData,
    output o_instr, o_ifValid, o_imemReq, o_imemAddr
  );

  modport master (
    output i_pc, i_flush, i_imemGnt, i_imemValid, i_imemData,
    input  o_instr, o_ifValid, o_imemReq, o_imemAddr
  );
endinterface

// File: rtl/ifetch_bridge.sv
// Instruction-fetch bridge: 2-entry tagged buffer with a combinational hit path and a
// single-outstanding memory request that prefetches PC+4 while the current PC hits.
module ifetch_bridge #(
  parameter int                     XLEN        = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP         = INSTR_WIDTH'(32'h13)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  ifetch_bridge_if.slave  bus
);
  localparam int TW = XLEN - 2;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [XLEN-1:0]        req_addr_reg, req_addr_next;
  logic                   discard_reg, discard_next;
  logic [1:0]             valid_reg;
  logic [TW-1:0]          tag_reg  [2];
  logic [INSTR_WIDTH-1:0] data_reg [2];

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] tgt_addr;
  logic [1:0]      hit_vec, tgt_vec, req_vec;
  logic            hit;
  logic            fetch_need;
  logic            keep_rsp;
  logic            victim;

  assign pc_plus4 = bus.i_pc + XLEN'(4);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      assign hit_vec[gi] = valid_reg[gi] && (tag_reg[gi] == bus.i_pc[XLEN-1:2]);
      assign tgt_vec[gi] = valid_reg[gi] && (tag_reg[gi] == tgt_addr[XLEN-1:2]);
      assign req_vec[gi] = valid_reg[gi] && (tag_reg[gi] == req_addr_reg[XLEN-1:2]);
    end
  endgenerate

  assign hit        = |hit_vec;
  assign tgt_addr   = hit ? pc_plus4 : bus.i_pc;
  assign fetch_need = ~|tgt_vec;

  // Keep/drop uses the PC of the response cycle, so a redirect that lands with the data wins.
  assign keep_rsp = (state_reg == ST_WAIT) && bus.i_imemValid && !discard_reg && !bus.i_flush &&
                    ((req_addr_reg == bus.i_pc) || (req_addr_reg == pc_plus4));

  always_comb begin
    victim = 1'b1;
    if (req_vec[0])                   victim = 1'b0;
    else if (req_vec[1])              victim = 1'b1;
    else if (!valid_reg[0])           victim = 1'b0;
    else if (!valid_reg[1])           victim = 1'b1;
    else if (hit_vec[1] && !hit_vec[0]) victim = 1'b0;
    else                              victim = 1'b1;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      req_addr_reg <= '0;
      discard_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      req_addr_reg <= req_addr_next;
      discard_reg  <= discard_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next    = state_reg;
    req_addr_next = req_addr_reg;
    discard_next  = discard_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fetch_need && !bus.i_flush) begin
          state_next    = ST_REQ;
          req_addr_next = tgt_addr;
        end
      end
      ST_REQ: begin
        if (bus.i_imemGnt) state_next = ST_WAIT;
        if (bus.i_flush)   discard_next = 1'b1;
      end
      ST_WAIT: begin
        if (bus.i_imemValid) begin
          state_next   = ST_IDLE;
          discard_next = 1'b0;
        end else if (bus.i_flush) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM / hit-path outputs
  always_comb begin
    bus.o_imemReq  = (state_reg == ST_REQ);
    bus.o_imemAddr = (state_reg == ST_REQ) ? req_addr_reg : '0;
    bus.o_ifValid  = hit;
    if (hit_vec[0])      bus.o_instr = data_reg[0];
    else if (hit_vec[1]) bus.o_instr = data_reg[1];
    else                 bus.o_instr = NOP;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_reg <= 2'b00;
    end else begin
      if (keep_rsp) valid_reg[victim] <= 1'b1;
      if (bus.i_flush) valid_reg <= 2'b00;
    end
  end

  // Tag/data payload needs no reset; valid bits gate every use.
  always_ff @(posedge i_clk) begin
    if (keep_rsp) begin
      tag_reg[victim]  <= req_addr_reg[XLEN-1:2];
      data_reg[victim] <= bus.i_imemData[INSTR_WIDTH-1:0];
    end
  end
endmodule
